// File: rtl/spectro_capture_pkg.sv
// Shared types and width helpers for the spectrogram capture core.
package spectro_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HDR     = 2'd2,
    DATA    = 2'd3
  } state_t;

  // Header goes out MSB first as {ts, len, trunc}; trunc sits at the bottom.
  localparam int unsigned HDR_TRUNC_W   = 1;
  localparam int unsigned HDR_TRUNC_LSB = 0;

  function automatic int unsigned enc_width(input int unsigned th_w);
    return $clog2(th_w + 1);
  endfunction

  function automatic int unsigned len_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned hdr_len_lsb();
    return HDR_TRUNC_LSB + HDR_TRUNC_W;
  endfunction

  function automatic int unsigned hdr_ts_lsb(input int unsigned len_w);
    return hdr_len_lsb() + len_w;
  endfunction

  function automatic int unsigned hdr_width(input int unsigned ts_w, input int unsigned len_w);
    return hdr_ts_lsb(len_w) + ts_w;
  endfunction

endpackage

// File: rtl/spectro_capture_core_thermo_encoder.sv
// Thermometer-to-binary encoder: highest set bit index + 1, or 0 when empty.
// Ports: code (TH_W thermometer input), value (encoded count).
module thermo_encoder
  import spectro_capture_pkg::*;
#(
  parameter int unsigned TH_W = 7
) (
  input  logic [TH_W-1:0]             code,
  output logic [enc_width(TH_W)-1:0]  value
);

  localparam int unsigned ENC_W = enc_width(TH_W);

  always_comb begin
    value = '0;
    for (int unsigned i = 0; i < TH_W; i++) begin
      if (code[i]) value = ENC_W'(i + 1);
    end
  end

endmodule

// File: rtl/spectro_capture_core.sv
// Spectrogram capture core: trigger detect, per-channel encode, event buffer,
// timestamp latch and per-lane serial framing with a valid/ready bit handshake.
// Ports: clk, reset (sync, active low), sample_en, ch, ts_in, trig_all,
// bit_ready in; serial_out, bit_valid, sof, eof, busy, missed out.
module spectro_capture_core
  import spectro_capture_pkg::*;
#(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned TH_W  = 7,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned QUIET = 4,
  parameter int unsigned TS_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_en,
  input  logic [N_CH*TH_W-1:0]   ch,
  input  logic [TS_W-1:0]        ts_in,
  input  logic                   trig_all,
  input  logic                   bit_ready,
  output logic [N_CH-1:0]        serial_out,
  output logic                   bit_valid,
  output logic                   sof,
  output logic                   eof,
  output logic                   busy,
  output logic [7:0]             missed
);

  localparam int unsigned ENC_W    = enc_width(TH_W);
  localparam int unsigned LEN_W    = len_width(DEPTH);
  localparam int unsigned AW       = addr_width(DEPTH);
  localparam int unsigned HDR_BITS = hdr_width(TS_W, LEN_W);
  localparam int unsigned CNT_W    = $clog2(HDR_BITS);
  localparam int unsigned QW       = $clog2(QUIET + 1);

  state_t                 state, state_next;
  logic [N_CH*ENC_W-1:0]  enc;
  logic [N_CH-1:0]        lsb;
  logic                   trig;

  logic [LEN_W-1:0]       len, len_inc, samp_idx, samp_next;
  logic [QW-1:0]          quiet_cnt, quiet_inc;
  logic                   trunc;
  logic [TS_W-1:0]        ts_reg;
  logic [CNT_W-1:0]       bit_cnt;

  logic [N_CH*ENC_W-1:0]  mem [DEPTH];
  logic [N_CH*ENC_W-1:0]  rd_data;
  logic [AW-1:0]          rd_addr, wr_addr;
  logic                   wr_en;

  logic                   accept, hdr_last, smp_last, last_smp, readout_done, missed_inc;
  logic [HDR_BITS-1:0]    hdr_word, hdr_shift;
  logic [ENC_W-1:0]       lane_word;

  for (genvar i = 0; i < N_CH; i++) begin : g_enc
    thermo_encoder #(.TH_W(TH_W)) u_enc (
      .code  (ch[i*TH_W +: TH_W]),
      .value (enc[i*ENC_W +: ENC_W])
    );
  end

  always_comb begin
    lsb = '0;
    for (int unsigned i = 0; i < N_CH; i++) lsb[i] = ch[i*TH_W];
    trig = trig_all ? (&lsb) : (|lsb);
  end

  always_comb begin
    accept       = bit_valid & bit_ready;
    hdr_last     = (bit_cnt == CNT_W'(HDR_BITS - 1));
    smp_last     = (bit_cnt == CNT_W'(ENC_W - 1));
    last_smp     = (samp_idx == len - LEN_W'(1));
    readout_done = (state == DATA) && accept && smp_last && last_smp;
    len_inc      = len + LEN_W'(1);
    quiet_inc    = trig ? '0 : quiet_cnt + QW'(1);
    missed_inc   = sample_en && trig &&
                   ((state == HDR) || ((state == DATA) && !readout_done));
    wr_en        = sample_en && (((state == IDLE) && trig) || (state == CAPTURE));
    wr_addr      = (state == IDLE) ? '0 : AW'(len);
  end

  // Read address runs one sample ahead so the next word is already
  // registered when the last bit of the current sample is accepted.
  always_comb begin
    samp_next = '0;
    if (state == DATA) begin
      samp_next = (accept && smp_last) ? samp_idx + LEN_W'(1) : samp_idx;
    end
    rd_addr = AW'(samp_next);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_en && trig) state_next = CAPTURE;
      CAPTURE: if (sample_en && ((quiet_inc == QW'(QUIET)) || (len_inc == LEN_W'(DEPTH))))
                 state_next = HDR;
      HDR:     if (accept && hdr_last) state_next = DATA;
      DATA:    if (readout_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    hdr_word = '0;
    hdr_word[hdr_ts_lsb(LEN_W) +: TS_W]   = ts_reg;
    hdr_word[hdr_len_lsb() +: LEN_W]      = len;
    hdr_word[HDR_TRUNC_LSB]               = trunc;
    hdr_shift = hdr_word << bit_cnt;
  end

  always_comb begin
    serial_out = '0;
    bit_valid  = 1'b0;
    sof        = 1'b0;
    eof        = 1'b0;
    lane_word  = '0;
    busy       = (state != IDLE);
    case (state)
      HDR: begin
        bit_valid     = 1'b1;
        serial_out[0] = hdr_shift[HDR_BITS-1];
        sof           = (bit_cnt == '0);
      end
      DATA: begin
        bit_valid = 1'b1;
        eof       = smp_last && last_smp;
        for (int unsigned i = 0; i < N_CH; i++) begin
          lane_word     = rd_data[i*ENC_W +: ENC_W] << bit_cnt;
          serial_out[i] = lane_word[ENC_W-1];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= enc;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      len       <= '0;
      quiet_cnt <= '0;
      trunc     <= 1'b0;
      ts_reg    <= '0;
      samp_idx  <= '0;
      bit_cnt   <= '0;
      missed    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (sample_en && trig) begin
            ts_reg    <= ts_in;
            len       <= LEN_W'(1);
            quiet_cnt <= '0;
            trunc     <= 1'b0;
            samp_idx  <= '0;
            bit_cnt   <= '0;
          end
        end
        CAPTURE: begin
          if (sample_en) begin
            len       <= len_inc;
            quiet_cnt <= quiet_inc;
            trunc     <= (len_inc == LEN_W'(DEPTH)) && trig;
          end
        end
        HDR: begin
          if (accept) bit_cnt <= hdr_last ? '0 : bit_cnt + CNT_W'(1);
        end
        DATA: begin
          if (accept) begin
            if (smp_last) begin
              bit_cnt  <= '0;
              samp_idx <= samp_idx + LEN_W'(1);
            end else begin
              bit_cnt  <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
      if (missed_inc && (missed != 8'hFF)) missed <= missed + 8'd1;
    end
  end

endmodule

// File: doc/spectro_capture_core.md
Name: spectro_capture_core

Overview:
Parametrised single-clock successor of the two-channel spectrogram capture path. Covers N_CH thermometer-coded filter channels and includes trigger detection, encoding, event buffering, timestamp latching and per-lane serial framing. Clock gating is replaced by a sample_en strobe, and bank switching is replaced by a single event buffer with a truncation flag. Sits between the comparator bank and the off-chip serial link.

Parameters:
N_CH, 2, number of channels and serial lanes
TH_W, 7, thermometer code width per channel
DEPTH, 256, maximum samples stored per event per channel
QUIET, 4, consecutive non-triggered sample strobes that close an event
TS_W, 32, timestamp width
ENC_W, $clog2(TH_W+1), encoded sample width (derived, not overridable)
LEN_W, $clog2(DEPTH+1), length field width (derived)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
sample_en  in  1  one-cycle strobe, one spectrogram sample
ch  in  N_CH*TH_W  thermometer inputs; channel i at [i*TH_W +: TH_W]
ts_in  in  TS_W  free-running real-time-clock value
trig_all  in  1  0: trigger when any ch[i][0]=1; 1: trigger when all ch[i][0]=1
bit_ready  in  1  downstream accepts the current bit
serial_out  out  N_CH  one bit per lane
bit_valid  out  1  serial_out holds a valid bit
sof  out  1  high with the first header bit
eof  out  1  high with the last data bit
busy  out  1  state != IDLE
missed  out  8  saturating count of triggers dropped during readout

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE. serial_out=0, bit_valid=0, sof=0, eof=0, busy=0, missed=0. All counters and flags cleared. Buffer contents are don't-care. Reset has priority over all other inputs and aborts any capture or readout in progress.
- Encoder: value = index of the highest set bit + 1, or 0 if no bit is set. Non-thermometer patterns (holes) are encoded by the highest set bit only.
- trig = trig_all ? AND of ch[i][0] : OR of ch[i][0].
- States:
  - IDLE: on sample_en && trig: write enc(ch) to addr 0 for every channel, latch ts_in into ts_reg, len=1, quiet_cnt=0, trunc=0, go to CAPTURE.
  - CAPTURE: on each sample_en, write at addr len and increment len. quiet_cnt = trig ? 0 : quiet_cnt+1. The end condition is evaluated on the strobe after that strobe's write:
    - quiet_cnt reaches QUIET, or
    - len reaches DEPTH; on this path set trunc=1 only if the strobe was triggered.
    - On either end condition, go to HDR next cycle. Quiet samples remain stored and counted in len.
  - HDR: lane 0 sends ts_reg (MSB first), then len (LEN_W bits, MSB first), then trunc (1 bit). Total TS_W+LEN_W+1 bits. Other lanes send 0.
  - DATA: lane i sends channel i samples, addr 0 to len-1, each ENC_W bits MSB first. All lanes run in lockstep.
  - After the last data bit is accepted: return to IDLE next cycle.
- Handshake:
  - bit_valid rises in the first cycle of HDR.
  - The bit advances only on bit_valid && bit_ready.
  - serial_out, sof and eof hold stable while bit_ready=0.
  - bit_valid stays high until eof is accepted, then drops the next cycle.
- sample_en with trig while in HDR or DATA: missed++, saturating at 255. The event is otherwise ignored.
- sample_en while in CAPTURE is always stored; no retrigger occurs.
- sample_en and end-of-readout in the same cycle: the strobe is dropped, not counted as missed, and not captured.
- Buffer: one N_CH*ENC_W wide, DEPTH deep register array. Single write port; one registered read port whose address is prefetched so the serial stream has no bubbles.
- Latency:
  - Trigger strobe to first header bit valid: QUIET (or DEPTH) strobes + 1 clk.
  - Each accepted bit produces the next bit in the following cycle.

Decomposition:
- Shared package holds:
  - state enum (IDLE, CAPTURE, HDR, DATA)
  - derived width functions (ENC_W, LEN_W)
  - header field order constants
- One sub-module: thermo_encoder (TH_W parameter, combinational), instantiated N_CH times.
- The serialiser remains inline in the core.

Test Plan:
- N_CH=2, TH_W=7. ch1=0000111 strobe, then 3 triggered strobes, then 4 quiet strobes. Required: len=8, trunc=0. Header is ts at first strobe, then 8, then 0. Lane 0 data starts 011 (value 3).
- Encoder sweep over all 128 patterns: required 0000000→0, 0000001→1, 1111111→7, 0100001→6.
- 300 triggered strobes with DEPTH=256: required len=256, trunc=1. The 257th–300th strobes arrive in HDR/DATA and give missed=44.
- bit_ready pulsed 1-in-3 randomly: required bitstream identical to the bit_ready=1 run, and sof/eof each accepted exactly once.
- trig_all=1 with ch[0][0]=1, ch[1][0]=0: required no capture and busy=0. Setting both bits to 1 starts the capture.
- reset=0 mid-DATA: required bit_valid=0 and busy=0 the cycle after the edge. The next trigger starts a clean frame with missed=0.
